// File: rtl/core_fetch_ctrl.sv
// Instruction fetch sequencer: drives the PC register strobes and the imem read port,
// and presents one fetched word at a time to decode over a valid/ready handshake.
module core_fetch_ctrl #(
    parameter int WORD_ADDR_WIDTH = 30
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       fetch_en_i,
    input  logic [WORD_ADDR_WIDTH-1:0] pc_waddr_i,
    output logic                       ctrl_incr_o,
    output logic                       ctrl_latch_o,
    output logic [WORD_ADDR_WIDTH-1:0] latch_waddr_o,
    output logic                       imem_req_o,
    output logic [WORD_ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                       imem_gnt_i,
    input  logic                       imem_rvalid_i,
    input  logic [31:0]                imem_rdata_i,
    input  logic                       redirect_i,
    input  logic [WORD_ADDR_WIDTH-1:0] redirect_waddr_i,
    output logic                       instr_valid_o,
    input  logic                       instr_ready_i,
    output logic [31:0]                instr_o,
    output logic [WORD_ADDR_WIDTH-1:0] instr_waddr_o,
    output logic                       busy_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FLUSH = 3'd4
    } state_t;

    state_t                       state;
    state_t                       state_nxt;
    state_t                       resume;
    logic [31:0]                  instr_q;
    logic [WORD_ADDR_WIDTH-1:0]   waddr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A redirected grant or response is stale, so neither address nor data is captured.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q <= '0;
            waddr_q <= '0;
        end else begin
            if (state == REQ && imem_gnt_i && !redirect_i) begin
                waddr_q <= pc_waddr_i;
            end
            if (state == WAIT && imem_rvalid_i && !redirect_i) begin
                instr_q <= imem_rdata_i;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        ctrl_incr_o   = 1'b0;
        imem_req_o    = 1'b0;
        imem_addr_o   = '0;
        ctrl_latch_o  = redirect_i;
        latch_waddr_o = redirect_i ? redirect_waddr_i : '0;
        resume        = fetch_en_i ? REQ : IDLE;

        case (state)
            IDLE: begin
                if (fetch_en_i) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                imem_req_o  = 1'b1;
                imem_addr_o = pc_waddr_i;
                if (imem_gnt_i) begin
                    if (redirect_i) begin
                        state_nxt = FLUSH;
                    end else begin
                        ctrl_incr_o = 1'b1;
                        state_nxt   = WAIT;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    state_nxt = redirect_i ? resume : HOLD;
                end else if (redirect_i) begin
                    state_nxt = FLUSH;
                end
            end
            HOLD: begin
                if (redirect_i || instr_ready_i) begin
                    state_nxt = resume;
                end
            end
            FLUSH: begin
                // Only one stale response can be outstanding; its arrival frees the port.
                if (imem_rvalid_i) begin
                    state_nxt = resume;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign instr_valid_o = (state == HOLD);
    assign instr_o       = instr_q;
    assign instr_waddr_o = waddr_q;
    assign busy_o        = (state != IDLE);

endmodule
